// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared defaults, mode/direction encodings and FSM states for shift_sweep_seq
package shift_seq_pkg;
  localparam int N_DEF = 32;
  localparam int M_DEF = 5;
  localparam logic [1:0] MODE_L = 2'b00;
  localparam logic [1:0] MODE_R = 2'b01;
  localparam logic [1:0] MODE_LR = 2'b10;
  localparam logic [1:0] MODE_RL = 2'b11;
  localparam logic LR_LEFT = 1'b0;
  localparam logic LR_RIGHT = 1'b1;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
endpackage

// File: rtl/shift_sweep_seq_if.sv
// shift_sweep_seq_if: request/beat bus between a controller (master) and shift_sweep_seq (slave)
// master drives start/mode/step/data_in/ready; slave drives valid/a/amt/lr/busy/done/beat_cnt
interface shift_sweep_seq_if import shift_seq_pkg::*; #(
  parameter int N = N_DEF,
  parameter int M = M_DEF
);
  logic start;
  logic [1:0] mode;
  logic [M-1:0] step;
  logic [N-1:0] data_in;
  logic ready;
  logic valid;
  logic [N-1:0] a;
  logic [M-1:0] amt;
  logic lr;
  logic busy;
  logic done;
  logic [M+1:0] beat_cnt;
  modport master (output start, mode, step, data_in, ready,
                  input valid, a, amt, lr, busy, done, beat_cnt);
  modport slave (input start, mode, step, data_in, ready,
                 output valid, a, amt, lr, busy, done, beat_cnt);
endinterface

// File: rtl/shift_amt_counter.sv
// shift_amt_counter: shift amount register advancing by a latched step, clearing on overflow
// ports: clk, reset, load (latch step, clear amt), adv (accepted beat), step_in, amt, ovf (amt+step >= N)
module shift_amt_counter #(
  parameter int N = 32,
  parameter int M = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         adv,
  input  logic [M-1:0] step_in,
  output logic [M-1:0] amt,
  output logic         ovf
);
  logic [M-1:0] step;
  logic [M:0] nxt;
  // one extra bit so amt+step can reach N without wrapping
  assign nxt = {1'b0, amt} + {1'b0, step};
  assign ovf = nxt >= (M+1)'(N);
  always_ff @(posedge clk) begin
    if (reset) begin
      amt <= '0;
      step <= M'(1);
    end else if (load) begin
      step <= (step_in == '0) ? M'(1) : step_in;
      amt <= '0;
    end else if (adv) begin
      amt <= ovf ? '0 : nxt[M-1:0];
    end
  end
endmodule

// File: rtl/shift_sweep_seq.sv
// shift_sweep_seq: sweeps a latched operand through shift amounts 0..N-1 in one or two directions
// ports: clk, reset (sync, active-high), bus (slave side of shift_sweep_seq_if)
module shift_sweep_seq import shift_seq_pkg::*; #(
  parameter int N = N_DEF,
  parameter int M = M_DEF
) (
  input logic clk,
  input logic reset,
  shift_sweep_seq_if.slave bus
);
  state_t state, state_nx;
  logic load, hs, ovf, multi, ph2, last;
  assign load = (state == IDLE) && bus.start;
  assign hs = bus.valid && bus.ready;
  // the sweep ends on overflow unless a two-phase mode is still in its first phase
  assign last = ovf && !(multi && !ph2);
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_comb begin
    bus.valid = state == SWEEP;
    bus.busy = state == SWEEP;
    bus.done = state == DONE;
    state_nx = (state == IDLE) ? (bus.start ? SWEEP : IDLE) :
               (state == SWEEP) ? ((hs && last) ? DONE : SWEEP) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.a <= '0;
      bus.lr <= LR_LEFT;
      bus.beat_cnt <= '0;
      multi <= 1'b0;
      ph2 <= 1'b0;
    end else if (load) begin
      bus.a <= bus.data_in;
      bus.lr <= (bus.mode == MODE_R || bus.mode == MODE_RL) ? LR_RIGHT : LR_LEFT;
      bus.beat_cnt <= '0;
      multi <= bus.mode == MODE_LR || bus.mode == MODE_RL;
      ph2 <= 1'b0;
    end else if (hs) begin
      bus.beat_cnt <= bus.beat_cnt + 1'b1;
      if (ovf && multi && !ph2) begin
        bus.lr <= ~bus.lr;
        ph2 <= 1'b1;
      end
    end
  end
  shift_amt_counter #(.N(N), .M(M)) u_cnt (
    .clk(clk),
    .reset(reset),
    .load(load),
    .adv(hs),
    .step_in(bus.step),
    .amt(bus.amt),
    .ovf(ovf)
  );
endmodule

// File: tb/tb_shift_sweep_seq.sv
// tb_shift_sweep_seq: directed self-checking bench for shift_sweep_seq
module tb_shift_sweep_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  shift_sweep_seq_if #(.N(32), .M(5)) bus ();
  shift_sweep_seq #(.N(32), .M(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag, input logic [31:0] cnt);
    chk({tag, "_valid"}, 32'(bus.valid), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_cnt"}, 32'(bus.beat_cnt), cnt);
  endtask

  task automatic sweep(input string tag, input logic [1:0] md, input logic [4:0] st,
                       input logic [31:0] d, input int inc, input int per,
                       input int phases, input logic lr0);
    bus.mode = md;
    bus.step = st;
    bus.data_in = d;
    bus.ready = 1'b1;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int p = 0; p < phases; p++)
      for (int k = 0; k < per; k++) begin
        chk({tag, "_valid"}, 32'(bus.valid), 1);
        chk({tag, "_busy"}, 32'(bus.busy), 1);
        chk({tag, "_amt"}, 32'(bus.amt), 32'(k * inc));
        chk({tag, "_lr"}, 32'(bus.lr), 32'(lr0 ^ p[0]));
        chk({tag, "_a"}, bus.a, d);
        chk({tag, "_done_low"}, 32'(bus.done), 0);
        tick;
      end
    chk({tag, "_end_valid"}, 32'(bus.valid), 0);
    chk({tag, "_end_done"}, 32'(bus.done), 1);
    chk({tag, "_end_busy"}, 32'(bus.busy), 0);
    chk({tag, "_end_cnt"}, 32'(bus.beat_cnt), 32'(per * phases));
    tick;
    idle_chk({tag, "_idle"}, 32'(per * phases));
    tick;
    idle_chk({tag, "_hold"}, 32'(per * phases));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mode = 2'b00;
    bus.step = 5'd0;
    bus.data_in = '0;
    bus.ready = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    idle_chk("rst", 0);
    chk("rst_amt", 32'(bus.amt), 0);
    chk("rst_a", bus.a, 0);
    chk("rst_lr", 32'(bus.lr), 0);

    sweep("l_s1", 2'b00, 5'd1, 32'h0000_00F0, 1, 32, 1, 1'b0);
    sweep("lr_s4", 2'b10, 5'd4, 32'hDEAD_BEEF, 4, 8, 2, 1'b0);
    sweep("rl_s7", 2'b11, 5'd7, 32'h0BAD_F00D, 7, 5, 2, 1'b1);

    // step 0 behaves as 1; ready pattern 1,0,0 per beat
    bus.mode = 2'b01;
    bus.step = 5'd0;
    bus.data_in = 32'h1234_5678;
    bus.ready = 1'b1;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      chk("r0_valid", 32'(bus.valid), 1);
      chk("r0_amt", 32'(bus.amt), 32'(k));
      chk("r0_lr", 32'(bus.lr), 1);
      bus.ready = 1'b0;
      tick;
      chk("r0_hold_amt", 32'(bus.amt), 32'(k));
      chk("r0_hold_lr", 32'(bus.lr), 1);
      chk("r0_hold_a", bus.a, 32'h1234_5678);
      chk("r0_hold_valid", 32'(bus.valid), 1);
      tick;
      chk("r0_hold2_amt", 32'(bus.amt), 32'(k));
      bus.ready = 1'b1;
      tick;
    end
    chk("r0_done", 32'(bus.done), 1);
    chk("r0_cnt", 32'(bus.beat_cnt), 32);
    tick;
    idle_chk("r0_idle", 32);

    // start pulses in SWEEP and DONE are ignored
    bus.mode = 2'b00;
    bus.step = 5'd8;
    bus.data_in = 32'h0000_00A5;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk("rs_amt0", 32'(bus.amt), 0);
    tick;
    chk("rs_amt1", 32'(bus.amt), 8);
    bus.start = 1'b1;
    bus.mode = 2'b01;
    bus.data_in = 32'h0000_00FF;
    tick;
    bus.start = 1'b0;
    chk("rs_a", bus.a, 32'h0000_00A5);
    chk("rs_amt2", 32'(bus.amt), 16);
    chk("rs_lr", 32'(bus.lr), 0);
    chk("rs_busy", 32'(bus.busy), 1);
    tick;
    chk("rs_amt3", 32'(bus.amt), 24);
    tick;
    chk("rs_done", 32'(bus.done), 1);
    chk("rs_cnt", 32'(bus.beat_cnt), 4);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    idle_chk("rs_after_done", 4);
    tick;
    idle_chk("rs_idle", 4);
    chk("rs_a_kept", bus.a, 32'h0000_00A5);

    // reset mid-sweep at beat 5, with start held during reset
    bus.mode = 2'b00;
    bus.step = 5'd1;
    bus.data_in = 32'h5555_AAAA;
    bus.ready = 1'b1;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) tick;
    chk("mr_amt5", 32'(bus.amt), 5);
    chk("mr_cnt5", 32'(bus.beat_cnt), 5);
    reset = 1'b1;
    bus.start = 1'b1;
    tick;
    reset = 1'b0;
    bus.start = 1'b0;
    idle_chk("mr_rst", 0);
    chk("mr_amt", 32'(bus.amt), 0);
    chk("mr_a", bus.a, 0);
    chk("mr_lr", 32'(bus.lr), 0);
    tick;
    idle_chk("mr_nostart", 0);
    sweep("mr_fresh", 2'b00, 5'd1, 32'h5555_AAAA, 1, 32, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shift_sweep_seq.md
SHIFT_SWEEP_SEQ -- requirements
Module: shift_sweep_seq

Interface
REQ-001 Parameter N, default 32: data width of the operand driven to the downstream barrel shifter.
REQ-002 Parameter M, default 5: shift-amount width, log2(N).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a sweep; sampled only in IDLE.
REQ-006 mode  input  2  sweep mode: 00 left only; 01 right only; 10 left then right; 11 right then left.
REQ-007 step  input  M  amount increment per beat; value 0 SHALL be treated as 1.
REQ-008 data_in  input  N  operand, latched at start.
REQ-009 ready  input  1  downstream accepts the current beat.
REQ-010 valid  output  1  a, amt and lr hold a valid beat.
REQ-011 a  output  N  latched operand.
REQ-012 amt  output  M  current shift amount.
REQ-013 lr  output  1  direction: 0 = left, 1 = right.
REQ-014 busy  output  1  high in SWEEP.
REQ-015 done  output  1  one-cycle pulse at sweep completion.
REQ-016 beat_cnt  output  M+2  handshakes completed in the current or last sweep.

Function
REQ-017 The FSM SHALL have three states: IDLE, SWEEP and DONE.
REQ-018 In IDLE with start=1, the block SHALL, on the next edge, latch data_in, mode and step (0 mapped to 1), set amt=0, set lr to the first-phase direction, clear beat_cnt, enter SWEEP and assert valid.
REQ-019 A handshake is valid=1 and ready=1 in the same cycle; each handshake SHALL increment beat_cnt by 1.
REQ-020 On a handshake, the block SHALL compute next = amt + step in M+1 bits; if next < N, amt SHALL become next on the following cycle with lr unchanged.
REQ-021 If next >= N and a second phase remains (modes 10 and 11, first phase), the block SHALL set amt=0, invert lr and stay in SWEEP; amt SHALL never wrap to a nonzero value.
REQ-022 If next >= N and no phase remains, the block SHALL deassert valid and enter DONE on the next edge.
REQ-023 While valid=1 and ready=0, a, amt and lr SHALL hold stable.
REQ-024 DONE SHALL last exactly one cycle with done=1 and then return to IDLE; done SHALL be 0 in all other states.
REQ-025 start SHALL be ignored in SWEEP and DONE; no re-latch and no restart.
REQ-026 Output latency: first valid beat in the cycle after start is sampled; with ready held at 1, one beat per cycle; done one cycle after the final handshake.
REQ-027 Beats per phase SHALL equal ceil(N/step); mode 1x SHALL produce twice that count.
REQ-028 beat_cnt SHALL hold its final value in IDLE until the next accepted start.

Reset
REQ-029 On reset=1 at any edge, including mid-sweep, the block SHALL enter IDLE with valid=0, busy=0, done=0, amt=0, lr=0, a=0 and beat_cnt=0, effective from the following cycle.
REQ-030 start asserted in the same cycle as reset SHALL be ignored.

Structure
REQ-031 The shared package shift_seq_pkg SHALL hold the N and M defaults, the mode encodings (MODE_L, MODE_R, MODE_LR, MODE_RL), the lr encodings and the FSM state encoding.
REQ-032 The amount/step logic (M+1-bit add, overflow compare, clear) SHALL be one sub-module, shift_amt_counter; the FSM and handshake logic SHALL stay in the top module.

Verification
REQ-033 mode=00, step=1, data_in=0x000000F0, ready=1 -> 32 beats with amt 0..31 and lr=0, done pulse in the cycle after amt=31 is accepted, beat_cnt=32.
REQ-034 mode=10, step=4 -> 8 beats with lr=0 and amt 0,4,...,28, then 8 beats with lr=1 and amt 0,...,28, beat_cnt=16, single done pulse.
REQ-035 mode=01, step=0, with ready toggling 1,0,0,1,... -> treated as step=1; a/amt/lr held stable while ready=0; 32 right beats total.
REQ-036 mode=11, step=7 -> right amt 0,7,14,21,28, then left amt 0,7,14,21,28; beat_cnt=10.
REQ-037 start re-pulsed during SWEEP with different data_in -> ignored; a unchanged, sweep completes normally.
REQ-038 reset asserted at beat 5 of a mode=00 sweep -> next cycle valid=0, busy=0, amt=0, beat_cnt=0; a subsequent start runs a full fresh sweep.
